sonic_bar_reg_mux: RTL and testbench
====================================

// Module: sonic_bar_reg_mux
// PURPOSE
// - BAR register access engine between sonic_rxtx_downstream_intf (reg_* side) and NUM_CH register clients (DMA rd/wr, IRQ, CMD, TX, ...).
// - Decodes channel from upper address bits, issues one-cycle prg write/read strobes, returns read data with valid, and serialises simultaneous rd/wr.
// - Parametrised successor of the fixed five-client BAR access path: any client count, address and data width, optional per-client read-completion timeout.
// PARAMETERS
// - NUM_CH    8   number of register clients (1..2**CH_SEL_W)
// - ADDR_W    8   request address width; [ADDR_W-1 -: CH_SEL_W] = channel, rest = prg_addr
// - CH_SEL_W  3   channel select bits
// - DATA_W    32  register data width
// - RD_LAT    1   fixed client read latency, cycles (1..7), used when timeout compiled out
// - TIMEOUT   16  max cycles to wait for prg_rdvalid (2..255)
// PORTS
// - clk_in            in   1                clock
// - rstn              in   1                async active-low reset
// - sel_ep_reg        in   1                request qualifier; rd/wr ignored when low
// - reg_wr_ena        in   1                write request pulse
// - reg_wr_addr       in   ADDR_W           write address
// - reg_wr_data       in   DATA_W           write data
// - reg_rd_ena        in   1                read request pulse
// - reg_rd_addr       in   ADDR_W           read address
// - reg_rd_data       out  DATA_W           read return data
// - reg_rd_data_valid out  1                one-cycle read return strobe
// - reg_busy          out  1                engine not IDLE; new requests not accepted
// - prg_addr          out  ADDR_W-CH_SEL_W  client register offset
// - prg_wrdata        out  DATA_W           client write data
// - prg_wrena         out  NUM_CH           one-hot write strobe
// - prg_rdena         out  NUM_CH           one-hot read strobe
// - prg_rddata        in   NUM_CH*DATA_W    client read data, channel c at [c*DATA_W +: DATA_W]
// - prg_rdvalid       in   NUM_CH           client read-data valid (timeout build only)
// - drop_cnt          out  8                saturating count of requests ignored while busy
// - timeout_cnt       out  8                saturating count of timed-out reads
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, pending slot empty. Reset mid-operation aborts; no valid is emitted.
// - FSM: IDLE -> WR (write accepted) | RD (read accepted) ; WR -> RD if pending read else IDLE; RD -> RESP ; RESP -> IDLE.
// - Accept only in IDLE with sel_ep_reg=1. reg_busy = (state != IDLE) | pending.
// - Write: request at T -> prg_wrena[ch], prg_addr, prg_wrdata registered, high in T+1 for exactly one cycle.
// - Read: request at T -> prg_rdena[ch] one cycle at T+1; data captured into reg_rd_data; reg_rd_data_valid one cycle in RESP.
// - Simultaneous rd+wr in IDLE: write first; read stored in 1-entry pending slot, prg_rdena at T+2.
// - Request while reg_busy=1: ignored, drop_cnt += 1 per ignored pulse (rd+wr same cycle = +2), saturates at 255.
// - Channel >= NUM_CH: write dropped (no strobe, still one WR cycle); read returns 0, valid at T+2.
// - reg_rd_data holds last value until next RESP; prg_addr/prg_wrdata hold last value.
// CONFIGURATION
// - Macro SONIC_REG_TIMEOUT_EN.
// - Defined: after prg_rdena cycle, sample prg_rddata[ch] on first cycle prg_rdvalid[ch]=1 (window of TIMEOUT cycles starting the cycle after prg_rdena); valid next cycle. No rdvalid in window -> reg_rd_data = {DATA_W/32{32'hDEAD_BEEF}} (truncated/replicated to DATA_W), timeout_cnt += 1 (saturating).
// - Undefined: prg_rdvalid ignored; data sampled RD_LAT cycles after prg_rdena; valid at T+2+RD_LAT; timeout_cnt tied 0.
// TESTING
// - Write addr 8'h45 data 32'h1234_5678 -> prg_wrena=8'b0000_0100 one cycle at T+1, prg_addr=5'h05, prg_wrdata=32'h1234_5678.
// - Read addr 8'h21, RD_LAT=1, macro off, client1 data 32'hCAFE_0001 -> prg_rdena[1] at T+1, valid at T+3 with 32'hCAFE_0001.
// - Same-cycle wr 8'h60 and rd 8'h61 -> prg_wrena[3] at T+1, prg_rdena[3] at T+2, one valid after; reg_busy high T+1 until IDLE.
// - Read addr 8'hE0 with NUM_CH=6 -> no prg_rdena, valid at T+2 with 0; write to 8'hE0 -> no prg_wrena.
// - Macro on, TIMEOUT=16, client never asserts rdvalid -> valid 17 cycles after prg_rdena with 32'hDEAD_BEEF, timeout_cnt=1; rdvalid at 3rd cycle -> client data.
// - Three reads issued while busy -> drop_cnt=3; rstn low during RD -> all outputs 0, no valid after release; 300 drops -> drop_cnt=255.

Source files
------------

// File: rtl/sonic_bar_reg_mux.sv
// -----------------------------------------------------------------------------
// sonic_bar_reg_mux
//
// BAR register access engine sitting between the downstream interface (reg_*
// side) and NUM_CH register clients (DMA rd/wr, IRQ, CMD, TX, ...). The upper
// CH_SEL_W address bits select the client, the remaining bits become the
// client register offset. Writes and reads are issued as one-cycle one-hot
// strobes; read data is returned with a one-cycle valid. A write and a read
// arriving in the same cycle are serialised: the write goes first and the
// read waits in a one-entry pending slot.
//
// Optional feature (macro SONIC_REG_TIMEOUT_EN):
//   defined   - read data is taken on the first prg_rdvalid of the addressed
//               client within TIMEOUT cycles after the read strobe; if none
//               arrives the engine returns a DEAD_BEEF pattern and bumps
//               timeout_cnt.
//   undefined - prg_rdvalid is ignored, data is taken RD_LAT cycles after the
//               read strobe, timeout_cnt is tied to zero.
//
// Ports
//   clk_in, rstn              clock, asynchronous active-low reset
//   sel_ep_reg                request qualifier (rd/wr ignored when low)
//   reg_wr_ena/addr/data      write request
//   reg_rd_ena/addr           read request
//   reg_rd_data/_valid        read return data and one-cycle strobe
//   reg_busy                  engine busy, new requests are dropped
//   prg_addr, prg_wrdata      client register offset and write data
//   prg_wrena, prg_rdena      one-hot client write / read strobes
//   prg_rddata, prg_rdvalid   client read data (channel c at c*DATA_W) / valid
//   drop_cnt                  saturating count of requests dropped while busy
//   timeout_cnt               saturating count of timed-out reads
// -----------------------------------------------------------------------------
module sonic_bar_reg_mux #(
    parameter int NUM_CH   = 8,
    parameter int ADDR_W   = 8,
    parameter int CH_SEL_W = 3,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic                       clk_in,
    input  logic                       rstn,
    input  logic                       sel_ep_reg,
    input  logic                       reg_wr_ena,
    input  logic [ADDR_W-1:0]          reg_wr_addr,
    input  logic [DATA_W-1:0]          reg_wr_data,
    input  logic                       reg_rd_ena,
    input  logic [ADDR_W-1:0]          reg_rd_addr,
    output logic [DATA_W-1:0]          reg_rd_data,
    output logic                       reg_rd_data_valid,
    output logic                       reg_busy,
    output logic [ADDR_W-CH_SEL_W-1:0] prg_addr,
    output logic [DATA_W-1:0]          prg_wrdata,
    output logic [NUM_CH-1:0]          prg_wrena,
    output logic [NUM_CH-1:0]          prg_rdena,
    input  logic [NUM_CH*DATA_W-1:0]   prg_rddata,
    input  logic [NUM_CH-1:0]          prg_rdvalid,
    output logic [7:0]                 drop_cnt,
    output logic [7:0]                 timeout_cnt
);

    localparam int OFF_W    = ADDR_W - CH_SEL_W;
    // The wait counter must cover both the fixed latency and the timeout window
    localparam int WAIT_MAX = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]          state;
    logic                pend_vld;
    logic [ADDR_W-1:0]   pend_addr;
    logic [CH_SEL_W-1:0] cur_ch;
    logic                cur_ok;
    logic [CNT_W-1:0]    lat_cnt;

    logic [CH_SEL_W-1:0] wr_ch;
    logic [CH_SEL_W-1:0] rd_ch;
    logic [ADDR_W-1:0]   rd_req_addr;
    logic                accept_wr;
    logic                start_rd;
    logic [1:0]          drop_inc;
    logic [8:0]          drop_sum;
    logic [DATA_W-1:0]   sel_data;

    function automatic logic ch_in_range(input logic [CH_SEL_W-1:0] ch);
        return int'(ch) < NUM_CH;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_SEL_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign reg_busy = (state != ST_IDLE) | pend_vld;

    // A read is launched either straight from IDLE or from the pending slot
    // once the preceding write strobe has gone out.
    assign rd_req_addr = (state == ST_WR) ? pend_addr : reg_rd_addr;
    assign wr_ch       = reg_wr_addr[ADDR_W-1 -: CH_SEL_W];
    assign rd_ch       = rd_req_addr[ADDR_W-1 -: CH_SEL_W];
    assign accept_wr   = (state == ST_IDLE) & sel_ep_reg & reg_wr_ena;
    assign start_rd    = ((state == ST_IDLE) & sel_ep_reg & reg_rd_ena & ~reg_wr_ena)
                       | ((state == ST_WR) & pend_vld);

    // Each request pulse seen while busy is one drop; rd+wr together count two.
    assign drop_inc = (sel_ep_reg & reg_busy) ? ({1'b0, reg_wr_ena} + {1'b0, reg_rd_ena}) : 2'd0;
    assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

    // Read data of the client being served; out-of-range channels see zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cur_ch) == i) sel_data = prg_rddata[i*DATA_W +: DATA_W];
        end
    end

`ifdef SONIC_REG_TIMEOUT_EN
    // Pattern returned for a read whose client never answered
    localparam logic [DATA_W-1:0] TMO_PATTERN =
        DATA_W'({((DATA_W + 31) / 32){32'hDEAD_BEEF}});

    logic       sel_valid;
    logic [7:0] tmo_q;

    always_comb begin
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cur_ch) == i) sel_valid = prg_rdvalid[i];
        end
    end

    assign timeout_cnt = tmo_q;
`else
    logic unused_rdvalid;
    assign unused_rdvalid = ^prg_rdvalid;
    assign timeout_cnt    = 8'd0;
`endif

    // Main engine: state, pending slot, strobes, read return and counters.
    // Strobes and the read valid default low every cycle so they are single
    // cycle pulses; offset, write data and read data hold between updates.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state             <= ST_IDLE;
            pend_vld          <= 1'b0;
            pend_addr         <= '0;
            cur_ch            <= '0;
            cur_ok            <= 1'b0;
            lat_cnt           <= '0;
            reg_rd_data       <= '0;
            reg_rd_data_valid <= 1'b0;
            prg_addr          <= '0;
            prg_wrdata        <= '0;
            prg_wrena         <= '0;
            prg_rdena         <= '0;
            drop_cnt          <= '0;
`ifdef SONIC_REG_TIMEOUT_EN
            tmo_q             <= '0;
`endif
        end else begin
            prg_wrena         <= '0;
            prg_rdena         <= '0;
            reg_rd_data_valid <= 1'b0;
            drop_cnt          <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

            case (state)
                ST_IDLE: begin
                    if (accept_wr) begin
                        state <= ST_WR;
                        // Writes to a missing client still spend one WR cycle
                        if (ch_in_range(wr_ch)) begin
                            prg_wrena  <= ch_onehot(wr_ch);
                            prg_addr   <= reg_wr_addr[OFF_W-1:0];
                            prg_wrdata <= reg_wr_data;
                        end
                        if (reg_rd_ena) begin
                            pend_vld  <= 1'b1;
                            pend_addr <= reg_rd_addr;
                        end
                    end
                end
                ST_WR: begin
                    if (pend_vld) pend_vld <= 1'b0;
                    else          state    <= ST_IDLE;
                end
                ST_RD: begin
                    if (!cur_ok) begin
                        reg_rd_data       <= '0;
                        reg_rd_data_valid <= 1'b1;
                        state             <= ST_RESP;
`ifdef SONIC_REG_TIMEOUT_EN
                    // lat_cnt == 0 is the strobe cycle; the window is 1..TIMEOUT
                    end else if (lat_cnt == '0) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else if (sel_valid) begin
                        reg_rd_data       <= sel_data;
                        reg_rd_data_valid <= 1'b1;
                        state             <= ST_RESP;
                    end else if (lat_cnt == CNT_W'(TIMEOUT)) begin
                        reg_rd_data       <= TMO_PATTERN;
                        reg_rd_data_valid <= 1'b1;
                        state             <= ST_RESP;
                        if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
`else
                    end else if (lat_cnt == CNT_W'(RD_LAT)) begin
                        reg_rd_data       <= sel_data;
                        reg_rd_data_valid <= 1'b1;
                        state             <= ST_RESP;
`endif
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Read launch overrides the WR-state return to IDLE above
            if (start_rd) begin
                state   <= ST_RD;
                cur_ch  <= rd_ch;
                cur_ok  <= ch_in_range(rd_ch);
                lat_cnt <= '0;
                if (ch_in_range(rd_ch)) begin
                    prg_rdena <= ch_onehot(rd_ch);
                    prg_addr  <= rd_req_addr[OFF_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sonic_bar_reg_mux.sv
// -----------------------------------------------------------------------------
// tb_sonic_bar_reg_mux
//
// Directed bench for sonic_bar_reg_mux with NUM_CH=6 so that channels 6 and 7
// are unpopulated. A transaction-level model turns each request into the
// cycles at which strobes, busy and read returns must appear; a compare
// process checks every DUT output against it on each falling edge. Hand
// computed literal checks pin the key timings. The client model answers a
// read strobe one cycle later with 32'hCAFE_0000 + channel (and, in the
// timeout build, raises prg_rdvalid rv_delay cycles after the strobe).
// -----------------------------------------------------------------------------
module tb_sonic_bar_reg_mux;

    localparam int NUM_CH   = 6;
    localparam int ADDR_W   = 8;
    localparam int CH_SEL_W = 3;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 1;
    localparam int TIMEOUT  = 16;
    localparam int OFF_W    = ADDR_W - CH_SEL_W;
    localparam int MAX_CYC  = 2048;

    logic                     clk_in      = 1'b0;
    logic                     rstn        = 1'b0;
    logic                     sel_ep_reg  = 1'b0;
    logic                     reg_wr_ena  = 1'b0;
    logic [ADDR_W-1:0]        reg_wr_addr = '0;
    logic [DATA_W-1:0]        reg_wr_data = '0;
    logic                     reg_rd_ena  = 1'b0;
    logic [ADDR_W-1:0]        reg_rd_addr = '0;
    logic [DATA_W-1:0]        reg_rd_data;
    logic                     reg_rd_data_valid;
    logic                     reg_busy;
    logic [OFF_W-1:0]         prg_addr;
    logic [DATA_W-1:0]        prg_wrdata;
    logic [NUM_CH-1:0]        prg_wrena;
    logic [NUM_CH-1:0]        prg_rdena;
    logic [NUM_CH*DATA_W-1:0] prg_rddata;
    logic [NUM_CH-1:0]        prg_rdvalid;
    logic [7:0]               drop_cnt;
    logic [7:0]               timeout_cnt;

    sonic_bar_reg_mux #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CH_SEL_W(CH_SEL_W),
        .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .rstn(rstn), .sel_ep_reg(sel_ep_reg),
        .reg_wr_ena(reg_wr_ena), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_ena(reg_rd_ena), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .reg_rd_data_valid(reg_rd_data_valid),
        .reg_busy(reg_busy), .prg_addr(prg_addr), .prg_wrdata(prg_wrdata),
        .prg_wrena(prg_wrena), .prg_rdena(prg_rdena),
        .prg_rddata(prg_rddata), .prg_rdvalid(prg_rdvalid),
        .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Register clients
    logic [NUM_CH-1:0] rd_d1   = '0;
    logic [NUM_CH-1:0] rv_mask = '0;
    logic [NUM_CH-1:0] data_ok;
    int                rv_cnt   = 0;
    int                rv_delay = 1;

    always @(posedge clk_in) begin
        rd_d1 <= prg_rdena;
        if (prg_rdena != '0) begin
            rv_mask <= prg_rdena;
            rv_cnt  <= 1;
        end else if (rv_mask != '0) begin
            rv_cnt <= rv_cnt + 1;
        end
    end

    assign prg_rdvalid = (rv_mask != '0 && rv_delay != 0 && rv_cnt == rv_delay) ? rv_mask : '0;
`ifdef SONIC_REG_TIMEOUT_EN
    assign data_ok = prg_rdvalid;
`else
    assign data_ok = rd_d1;
`endif

    always_comb begin
        prg_rddata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            prg_rddata[c*DATA_W +: DATA_W] = data_ok[c] ? (32'hCAFE_0000 + 32'(c))
                                                        : (32'hBAD0_0000 + 32'(c));
        end
    end

    // Expected-behaviour timeline, indexed by cycle
    logic [NUM_CH-1:0] exp_wr    [MAX_CYC];
    logic [NUM_CH-1:0] exp_rd    [MAX_CYC];
    bit                exp_vld   [MAX_CYC];
    logic [DATA_W-1:0] exp_vdata [MAX_CYC];
    bit                exp_busy  [MAX_CYC];
    bit                addr_set  [MAX_CYC];
    logic [OFF_W-1:0]  addr_val  [MAX_CYC];
    bit                wd_set    [MAX_CYC];
    logic [DATA_W-1:0] wd_val    [MAX_CYC];
    bit                tmo_inc   [MAX_CYC];

    int free_at    = 0;
    int drop_model = 0;
    logic [OFF_W-1:0]  run_addr = '0;
    logic [DATA_W-1:0] run_wd   = '0;
    logic [DATA_W-1:0] run_data = '0;
    int                run_tmo  = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic void clear_from(input int c0);
        for (int i = c0; i < MAX_CYC; i++) begin
            exp_wr[i] = '0;  exp_rd[i] = '0;  exp_vld[i] = 1'b0; exp_vdata[i] = '0;
            exp_busy[i] = 1'b0; addr_set[i] = 1'b0; addr_val[i] = '0;
            wd_set[i] = 1'b0; wd_val[i] = '0; tmo_inc[i] = 1'b0;
        end
    endfunction

    // Read whose strobe cycle is t: schedule strobe, return and busy window
    function automatic void model_read(input int t, input logic [ADDR_W-1:0] addr);
        int ch;
        int v;
        logic [DATA_W-1:0] d;
        ch = int'(addr[ADDR_W-1 -: CH_SEL_W]);
        if (ch >= NUM_CH) begin
            v = t + 1;
            d = '0;
        end else begin
            exp_rd[t][ch] = 1'b1;
            addr_set[t]   = 1'b1;
            addr_val[t]   = addr[OFF_W-1:0];
`ifdef SONIC_REG_TIMEOUT_EN
            if (rv_delay >= 1 && rv_delay <= TIMEOUT) begin
                v = t + rv_delay + 1;
                d = 32'hCAFE_0000 + 32'(ch);
            end else begin
                v = t + TIMEOUT + 1;
                d = 32'hDEAD_BEEF;
                tmo_inc[v] = 1'b1;
            end
`else
            v = t + 1 + RD_LAT;
            d = 32'hCAFE_0000 + 32'(ch);
`endif
        end
        exp_vld[v]   = 1'b1;
        exp_vdata[v] = d;
        for (int c = t; c <= v; c++) exp_busy[c] = 1'b1;
        free_at = v + 1;
    endfunction

    // Drive one request for one cycle and record what it must cause
    task automatic applyStimulus(input logic sel, input logic wr,
                                 input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata,
                                 input logic rd, input logic [ADDR_W-1:0] raddr);
        int t;
        int drops;
        int wch;
        t     = cyc;
        drops = 0;
        sel_ep_reg  = sel;
        reg_wr_ena  = wr;  reg_wr_addr = waddr; reg_wr_data = wdata;
        reg_rd_ena  = rd;  reg_rd_addr = raddr;
        if (sel && (wr || rd)) begin
            if (t >= free_at) begin
                if (wr) begin
                    wch = int'(waddr[ADDR_W-1 -: CH_SEL_W]);
                    if (wch < NUM_CH) begin
                        exp_wr[t+1][wch] = 1'b1;
                        addr_set[t+1] = 1'b1; addr_val[t+1] = waddr[OFF_W-1:0];
                        wd_set[t+1]   = 1'b1; wd_val[t+1]   = wdata;
                    end
                    exp_busy[t+1] = 1'b1;
                    free_at = t + 2;
                    if (rd) model_read(t + 2, raddr);
                end else begin
                    model_read(t + 1, raddr);
                end
            end else begin
                drops = int'(wr) + int'(rd);
            end
        end
        @(posedge clk_in);
        #1;
        sel_ep_reg = 1'b0; reg_wr_ena = 1'b0; reg_rd_ena = 1'b0;
        drop_model = (drop_model + drops > 255) ? 255 : drop_model + drops;
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        rstn = 1'b0;
        clear_from(cyc);
        drop_model = 0;
        next_cycle(n);
        rstn = 1'b1;
        free_at = cyc;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk_in) begin
        if (!rstn) begin
            run_addr = '0; run_wd = '0; run_data = '0; run_tmo = 0;
            checkOutput("rst_prg_wrena", 64'(prg_wrena), 64'd0);
            checkOutput("rst_prg_rdena", 64'(prg_rdena), 64'd0);
            checkOutput("rst_rd_valid",  64'(reg_rd_data_valid), 64'd0);
            checkOutput("rst_rd_data",   64'(reg_rd_data), 64'd0);
            checkOutput("rst_busy",      64'(reg_busy), 64'd0);
            checkOutput("rst_prg_addr",  64'(prg_addr), 64'd0);
            checkOutput("rst_prg_wrdata",64'(prg_wrdata), 64'd0);
            checkOutput("rst_drop_cnt",  64'(drop_cnt), 64'd0);
            checkOutput("rst_tmo_cnt",   64'(timeout_cnt), 64'd0);
        end else if (cyc < MAX_CYC) begin
            if (addr_set[cyc]) run_addr = addr_val[cyc];
            if (wd_set[cyc])   run_wd   = wd_val[cyc];
            if (exp_vld[cyc])  run_data = exp_vdata[cyc];
            if (tmo_inc[cyc] && run_tmo < 255) run_tmo++;
            checkOutput("prg_wrena",   64'(prg_wrena), 64'(exp_wr[cyc]));
            checkOutput("prg_rdena",   64'(prg_rdena), 64'(exp_rd[cyc]));
            checkOutput("rd_valid",    64'(reg_rd_data_valid), 64'(exp_vld[cyc]));
            checkOutput("rd_data",     64'(reg_rd_data), 64'(run_data));
            checkOutput("busy",        64'(reg_busy), 64'(exp_busy[cyc]));
            checkOutput("prg_addr",    64'(prg_addr), 64'(run_addr));
            checkOutput("prg_wrdata",  64'(prg_wrdata), 64'(run_wd));
            checkOutput("drop_cnt",    64'(drop_cnt), 64'(drop_model));
            checkOutput("timeout_cnt", 64'(timeout_cnt), 64'(run_tmo));
        end
    end

    initial begin
        clear_from(0);
        repeat (3) @(posedge clk_in);
        #1;
        rstn = 1'b1;
        free_at = cyc;
        next_cycle(2);

        $display("[TB] write 8'h45");
        applyStimulus(1'b1, 1'b1, 8'h45, 32'h1234_5678, 1'b0, 8'h00);
        @(negedge clk_in);
        checkOutput("lit_wr45_strobe", 64'(prg_wrena), 64'h04);
        checkOutput("lit_wr45_addr",   64'(prg_addr), 64'h05);
        checkOutput("lit_wr45_data",   64'(prg_wrdata), 64'h1234_5678);
        next_cycle(1);
        @(negedge clk_in);
        checkOutput("lit_wr45_onecyc", 64'(prg_wrena), 64'h00);
        next_cycle(2);

        $display("[TB] read 8'h21");
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h21);
        @(negedge clk_in);
        checkOutput("lit_rd21_strobe", 64'(prg_rdena), 64'h02);
        next_cycle(1);
        @(negedge clk_in);
        checkOutput("lit_rd21_early",  64'(reg_rd_data_valid), 64'd0);
        next_cycle(1);
        @(negedge clk_in);
        checkOutput("lit_rd21_valid",  64'(reg_rd_data_valid), 64'd1);
        checkOutput("lit_rd21_data",   64'(reg_rd_data), 64'hCAFE_0001);
        next_cycle(2);

        $display("[TB] same-cycle write 8'h60 / read 8'h61");
        applyStimulus(1'b1, 1'b1, 8'h60, 32'hAAAA_5555, 1'b1, 8'h61);
        @(negedge clk_in);
        checkOutput("lit_wr60_strobe", 64'(prg_wrena), 64'h08);
        checkOutput("lit_wr60_nord",   64'(prg_rdena), 64'h00);
        checkOutput("lit_wr60_busy",   64'(reg_busy), 64'd1);
        next_cycle(1);
        @(negedge clk_in);
        checkOutput("lit_rd61_strobe", 64'(prg_rdena), 64'h08);
        next_cycle(4);

        $display("[TB] unpopulated channel 7");
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'hE0);
        @(negedge clk_in);
        checkOutput("lit_rdE0_nostrobe", 64'(prg_rdena), 64'h00);
        next_cycle(1);
        @(negedge clk_in);
        checkOutput("lit_rdE0_valid", 64'(reg_rd_data_valid), 64'd1);
        checkOutput("lit_rdE0_data",  64'(reg_rd_data), 64'd0);
        next_cycle(2);
        applyStimulus(1'b1, 1'b1, 8'hE0, 32'hFFFF_0000, 1'b0, 8'h00);
        @(negedge clk_in);
        checkOutput("lit_wrE0_nostrobe", 64'(prg_wrena), 64'h00);
        checkOutput("lit_wrE0_wdhold",   64'(prg_wrdata), 64'hAAAA_5555);
        next_cycle(2);

        $display("[TB] reset during read");
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h22);
        pulse_reset(2);
        next_cycle(5);

        $display("[TB] drops while busy");
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h41);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h42);
        @(negedge clk_in);
        checkOutput("lit_drop3", 64'(drop_cnt), 64'd3);
        next_cycle(1);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h43);
        applyStimulus(1'b1, 1'b1, 8'h44, 32'h5, 1'b1, 8'h44);
        next_cycle(4);
        @(negedge clk_in);
        checkOutput("lit_drop5", 64'(drop_cnt), 64'd5);
        next_cycle(1);

        $display("[TB] misc patterns");
        applyStimulus(1'b0, 1'b1, 8'h01, 32'h1111_1111, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'h1F, 32'h0BAD_F00D, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hBF, 32'hFFFF_FFFF, 1'b0, 8'h00);
        next_cycle(2);
        applyStimulus(1'b1, 1'b1, 8'hBF, 32'hFFFF_FFFF, 1'b0, 8'h00);
        next_cycle(2);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h1F);
        next_cycle(4);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'hA7);
        next_cycle(4);

`ifdef SONIC_REG_TIMEOUT_EN
        $display("[TB] read timeout");
        rv_delay = 0;
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h40);
        next_cycle(17);
        @(negedge clk_in);
        checkOutput("lit_tmo_valid", 64'(reg_rd_data_valid), 64'd1);
        checkOutput("lit_tmo_data",  64'(reg_rd_data), 64'hDEAD_BEEF);
        checkOutput("lit_tmo_cnt",   64'(timeout_cnt), 64'd1);
        next_cycle(2);
        rv_delay = 3;
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h40);
        next_cycle(4);
        @(negedge clk_in);
        checkOutput("lit_rv3_valid", 64'(reg_rd_data_valid), 64'd1);
        checkOutput("lit_rv3_data",  64'(reg_rd_data), 64'hCAFE_0002);
        next_cycle(2);
        rv_delay = 1;
`endif

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 400; i++)
            applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h21);
        next_cycle(4);
        @(negedge clk_in);
        checkOutput("lit_drop_sat", 64'(drop_cnt), 64'd255);
        next_cycle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
